// File: rtl/peripherals_pkg.sv
// Shared peripheral types: button indices, the raw button vector and the
// event code pushed into the button event FIFO.
package peripherals;

   localparam int NUM_BUTTONS = 5;
   localparam int BTN_LEFT    = 0;
   localparam int BTN_RIGHT   = 1;
   localparam int BTN_UP      = 2;
   localparam int BTN_DOWN    = 3;
   localparam int BTN_CENTER  = 4;

   // One press and one release pending slot per button, keyed index*2 + release.
   localparam int NUM_PENDING = 2 * NUM_BUTTONS;

   typedef logic [NUM_BUTTONS-1:0] buttons_t;

   typedef struct packed {
      logic       is_release;
      logic [2:0] index;
   } input_event_t;

   function automatic input_event_t pending_to_event(input int unsigned slot);
      input_event_t ev;
      ev.is_release = slot[0];
      ev.index      = 3'(slot >> 1);
      return ev;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button conditioner: two-flop synchroniser, stability counter and
// accepted level, with a one-cycle toggle strobe aligned to the level change.
module button_debouncer
   import peripherals::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
)(
   input  logic clock_100mhz,
   input  logic reset,
   input  logic button_raw,
   output logic level,
   output logic toggle
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] count;

   // Combinational so the caller can capture the edge on the same clock as the level flips.
   assign toggle = (sync_2 != level) && (count == CNT_LAST);

   always_ff @(posedge clock_100mhz) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         count  <= '0;
         level  <= 1'b0;
      end else begin
         sync_1 <= button_raw;
         sync_2 <= sync_1;
         if ((sync_2 == level) || toggle) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
         if (toggle) begin
            level <= ~level;
         end
      end
   end

endmodule

// File: rtl/button_event_unit.sv
// Synchronises switches, debounces buttons and queues press/release events
// for the CPU in a small FIFO with a valid/ack pop interface.
module button_event_unit
   import peripherals::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int FIFO_DEPTH      = 4
)(
   input  logic         clock_100mhz,
   input  logic         reset,
   input  buttons_t     buttons,
   input  logic [15:0]  switches,
   output logic [15:0]  switches_sync,
   output buttons_t     buttons_level,
   output logic         event_valid,
   output input_event_t event_code,
   input  logic         event_ack,
   output logic         overflow,
   input  logic         clear_overflow
);

   localparam int               PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

   logic [15:0]            switches_meta;
   buttons_t               toggles;
   logic [NUM_PENDING-1:0] pending;
   logic [NUM_PENDING-1:0] set_mask;
   logic [NUM_PENDING-1:0] push_mask;
   logic [NUM_PENDING-1:0] lost_mask;
   logic [3:0]             push_slot;
   logic                   push_any;
   logic                   push_en;
   logic                   pop;
   logic                   fifo_full;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;
   input_event_t           fifo_mem [FIFO_DEPTH];

   always_ff @(posedge clock_100mhz) begin
      if (!reset) begin
         switches_meta <= '0;
         switches_sync <= '0;
      end else begin
         switches_meta <= switches;
         switches_sync <= switches_meta;
      end
   end

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clock_100mhz (clock_100mhz),
         .reset        (reset),
         .button_raw   (buttons[i]),
         .level        (buttons_level[i]),
         .toggle       (toggles[i])
      );
      assign set_mask[2*i]   = toggles[i] & ~buttons_level[i];
      assign set_mask[2*i+1] = toggles[i] &  buttons_level[i];
   end

   // Handshake: event_code is the FIFO head whenever event_valid is high and
   // holds until popped; an edge with event_ack and event_valid both high pops
   // it. event_ack while event_valid is low has no effect.
   assign pop       = event_ack && event_valid;
   assign fifo_full = (count == FULL_COUNT);
   assign push_en   = push_any && (!fifo_full || pop);

   always_comb begin
      push_any  = 1'b0;
      push_slot = '0;
      for (int i = NUM_PENDING - 1; i >= 0; i--) begin
         if (pending[i]) begin
            push_any  = 1'b1;
            push_slot = 4'(i);
         end
      end
      push_mask = push_en ? (NUM_PENDING'(1) << push_slot) : '0;
   end

   // A slot being drained this cycle can take a new event without loss.
   assign lost_mask = set_mask & pending & ~push_mask;

   always_ff @(posedge clock_100mhz) begin
      if (!reset) begin
         pending  <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         pending <= (pending & ~push_mask) | set_mask;
         if (|lost_mask) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_en && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push_en) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clock_100mhz) begin
      if (push_en) begin
         fifo_mem[wr_ptr] <= pending_to_event(32'(push_slot));
      end
   end

   assign event_valid = (count != '0);
   assign event_code  = event_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit with a short debounce window.
module tb_button_event_unit;
   import peripherals::*;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic         clock_100mhz = 1'b0;
   logic         reset;
   buttons_t     buttons;
   logic [15:0]  switches;
   logic [15:0]  switches_sync;
   buttons_t     buttons_level;
   logic         event_valid;
   input_event_t event_code;
   logic         event_ack;
   logic         overflow;
   logic         clear_overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  btn;
      logic [15:0] sw;
      logic        ack;
      logic        clr;
      int          cyc;
      logic [4:0]  exp_lvl;
      logic        exp_valid;
      logic [3:0]  exp_code;
      logic        exp_ovf;
      logic [15:0] exp_sw;
   } vec_t;

   vec_t vecs[$];

   button_event_unit #(
      .DEBOUNCE_CYCLES (DEB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clock_100mhz   (clock_100mhz),
      .reset          (reset),
      .buttons        (buttons),
      .switches       (switches),
      .switches_sync  (switches_sync),
      .buttons_level  (buttons_level),
      .event_valid    (event_valid),
      .event_code     (event_code),
      .event_ack      (event_ack),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   // clock / reset
   always #5 clock_100mhz = ~clock_100mhz;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clock_100mhz);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [4:0] btn, input logic [15:0] sw, input logic ack,
                      input logic clr, input int cyc, input logic [4:0] lvl,
                      input logic v, input logic [3:0] code, input logic ovf,
                      input logic [15:0] esw);
      vec_t r;
      r.btn = btn; r.sw = sw; r.ack = ack; r.clr = clr; r.cyc = cyc;
      r.exp_lvl = lvl; r.exp_valid = v; r.exp_code = code; r.exp_ovf = ovf; r.exp_sw = esw;
      vecs.push_back(r);
   endtask

   task automatic check_all(input string tag, input logic [4:0] lvl, input logic v,
                            input logic [3:0] code, input logic ovf, input logic [15:0] sw);
      check({tag, "_level"},    16'(buttons_level), 16'(lvl));
      check({tag, "_valid"},    16'(event_valid),   16'(v));
      check({tag, "_code"},     16'(event_code),    16'(code));
      check({tag, "_overflow"}, 16'(overflow),      16'(ovf));
      check({tag, "_sw_sync"},  switches_sync,      sw);
   endtask

   initial begin
      logic [15:0] s;
      s = 16'hA5C3;

      // switches: one edge still old, second edge shows the new value
      add(5'b00000, s, 0, 0, 1, 5'b00000, 0, 4'h0, 0, 16'h0000);
      add(5'b00000, s, 0, 0, 1, 5'b00000, 0, 4'h0, 0, s);
      // press up: level after 6 edges, event after 7, held 20 total
      add(5'b00100, s, 0, 0, 6,  5'b00100, 0, 4'h0, 0, s);
      add(5'b00100, s, 0, 0, 1,  5'b00100, 1, 4'h2, 0, s);
      add(5'b00100, s, 0, 0, 13, 5'b00100, 1, 4'h2, 0, s);
      add(5'b00100, s, 1, 0, 1,  5'b00100, 0, 4'h0, 0, s);
      add(5'b00000, s, 0, 0, 6,  5'b00000, 0, 4'h0, 0, s);
      add(5'b00000, s, 0, 0, 1,  5'b00000, 1, 4'hA, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 0, 4'h0, 0, s);
      // center glitch of 3 cycles: ignored
      add(5'b10000, s, 0, 0, 3,  5'b00000, 0, 4'h0, 0, s);
      add(5'b00000, s, 0, 0, 10, 5'b00000, 0, 4'h0, 0, s);
      // left + down together
      add(5'b01001, s, 0, 0, 6,  5'b01001, 0, 4'h0, 0, s);
      add(5'b01001, s, 0, 0, 1,  5'b01001, 1, 4'h0, 0, s);
      add(5'b01001, s, 0, 0, 1,  5'b01001, 1, 4'h0, 0, s);
      add(5'b01001, s, 1, 0, 1,  5'b01001, 1, 4'h3, 0, s);
      add(5'b01001, s, 1, 0, 1,  5'b01001, 0, 4'h0, 0, s);
      add(5'b00000, s, 0, 0, 6,  5'b00000, 0, 4'h0, 0, s);
      add(5'b00000, s, 0, 0, 2,  5'b00000, 1, 4'h8, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 1, 4'hB, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 0, 4'h0, 0, s);
      // six events, no ack: four queued, two pending, then drained in order
      add(5'b00111, s, 0, 0, 9,  5'b00111, 1, 4'h0, 0, s);
      add(5'b00000, s, 0, 0, 9,  5'b00000, 1, 4'h0, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 1, 4'h1, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 1, 4'h2, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 1, 4'h8, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 1, 4'h9, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 1, 4'hA, 0, s);
      add(5'b00000, s, 1, 0, 1,  5'b00000, 0, 4'h0, 0, s);
      // overflow: FIFO full, center press pending, release then press again
      add(5'b01111, s, 0, 0, 10, 5'b01111, 1, 4'h0, 0, s);
      add(5'b11111, s, 0, 0, 6,  5'b11111, 1, 4'h0, 0, s);
      add(5'b01111, s, 0, 0, 6,  5'b01111, 1, 4'h0, 0, s);
      add(5'b11111, s, 0, 0, 6,  5'b11111, 1, 4'h0, 1, s);
      add(5'b11111, s, 0, 0, 3,  5'b11111, 1, 4'h0, 1, s);
      add(5'b11111, s, 0, 1, 1,  5'b11111, 1, 4'h0, 0, s);
      add(5'b11111, s, 1, 0, 1,  5'b11111, 1, 4'h1, 0, s);
      add(5'b11111, s, 1, 0, 1,  5'b11111, 1, 4'h2, 0, s);
      add(5'b11111, s, 1, 0, 1,  5'b11111, 1, 4'h3, 0, s);
      add(5'b11111, s, 1, 0, 1,  5'b11111, 1, 4'h4, 0, s);
      add(5'b11111, s, 1, 0, 1,  5'b11111, 1, 4'hC, 0, s);
      add(5'b11111, s, 1, 0, 1,  5'b11111, 0, 4'h0, 0, s);

      reset = 1'b0;
      buttons = '0;
      switches = '0;
      event_ack = 1'b0;
      clear_overflow = 1'b0;
      step(3);
      check_all("reset", 5'b00000, 0, 4'h0, 0, 16'h0000);
      reset = 1'b1;

      for (int i = 0; i < 100; i++) begin
         step(1);
         check($sformatf("idle%0d_valid", i), 16'(event_valid), 16'h0000);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         buttons        = vecs[i].btn;
         switches       = vecs[i].sw;
         event_ack      = vecs[i].ack;
         clear_overflow = vecs[i].clr;
         step(vecs[i].cyc);
         check_all($sformatf("v%0d", i), vecs[i].exp_lvl, vecs[i].exp_valid,
                   vecs[i].exp_code, vecs[i].exp_ovf, vecs[i].exp_sw);
      end
      event_ack = 1'b0;
      clear_overflow = 1'b0;

      // release all: two release events queued, three still pending
      buttons = 5'b00000;
      step(8);
      check_all("rel_all", 5'b00000, 1, 4'h8, 0, s);

      // reset with queued events while buttons are held through it
      buttons = 5'b11111;
      reset = 1'b0;
      step(2);
      check_all("mid_reset", 5'b00000, 0, 4'h0, 0, 16'h0000);
      reset = 1'b1;
      step(6);
      check_all("post_reset_lvl", 5'b11111, 0, 4'h0, 0, s);
      step(1);
      check_all("post_reset_ev", 5'b11111, 1, 4'h0, 0, s);

      // scoreboard report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_event_unit.md
# button_event_unit

Input-side conditioner for the board's push-buttons and slide switches, sitting between the raw pins and the peripheral status bus feeding the CPU. It synchronises all inputs, debounces the five buttons, and converts debounced press/release edges into a small FIFO of event codes. The CPU pops that FIFO with a valid/ack handshake. This is the input counterpart of the display and LED output path driven from the peripheral control bus.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); minimum 2
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2

Ports:
- clock_100mhz  input  1  system clock
- reset  input  1  synchronous, active-low reset
- buttons  input  buttons_t (5)  raw button pins, active-high
- switches  input  16  raw slide switches
- switches_sync  output  16  two-flop synchronised switches
- buttons_level  output  5  debounced button levels, bit order = button index
- event_valid  output  1  FIFO non-empty
- event_code  output  input_event_t (4)  head of FIFO: {release, index[2:0]}
- event_ack  input  1  pop head; ignored when event_valid is low
- overflow  output  1  sticky: an event was lost
- clear_overflow  input  1  clears overflow

## Operation

- Button index: 0 left, 1 right, 2 up, 3 down, 4 center.
- Synchronisation: every button and switch bit passes through two flops. switches_sync is stage 2; switches get no debounce and generate no events.
- Debounce, per button: the counter counts cycles where the synchronised value differs from buttons_level. It clears whenever the two are equal. When the count reaches DEBOUNCE_CYCLES, buttons_level toggles and the counter clears.
- Edge capture: 10 pending bits, one press and one release per button.
  - A 0→1 toggle sets press pending; a 1→0 toggle sets release pending.
  - If the target pending bit is already set, the event is lost and overflow sets.
- Arbiter: each cycle with FIFO not full (or full with event_ack accepted that cycle), push the lowest pending bit.
  - Priority key is index*2 + release, so press is ahead of release within a button.
  - The pushed pending bit clears.
- FIFO: registered storage. Push and pop in the same cycle are both accepted, including when full (count unchanged) and when count is 1.
- While the FIFO is full with no ack, pending bits hold. This is a stall, not a loss.
- overflow: set and clear_overflow in the same cycle → overflow stays 1.

## Timing

- Reset (reset low at an edge):
  - Sync flops, buttons_level, counters, pending bits and FIFO count all go to 0.
  - event_valid = 0, event_code = 0, overflow = 0, switches_sync = 0.
  - Reset mid-debounce or with a non-empty FIFO discards everything.
  - A button held through reset release produces a press event once debounced.
- Switch latency: a pin change sampled at edge k appears on switches_sync after edge k+1.
- Button latency, for a raw change sampled at edge k and held stable:
  - Stage 2 holds the value after edge k+1.
  - buttons_level toggles and pending sets at edge k+1+DEBOUNCE_CYCLES.
  - The push occurs at edge k+2+DEBOUNCE_CYCLES; event_valid is high after that edge, assuming no higher-priority pending bit and FIFO not full.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no level change and no event.
- Pop: event_ack high with event_valid high at edge n → the head advances after edge n. event_valid drops after edge n if the FIFO becomes empty.
- event_code is stable while event_valid is high and no ack is given.

## Structure

- Package peripherals: button index constants, NUM_BUTTONS = 5, and the input_event_t struct (release bit, 3-bit index). buttons_t already lives there.
- Sub-module button_debouncer: one instance per button via generate. It contains the 2-flop sync, the counter and the level register, with a toggle-pulse output.
- The pending bits, arbiter and FIFO are inline in button_event_unit.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4.

- Reset then idle: all outputs 0; no event_valid for 100 cycles.
- Press up (index 2) cleanly for 20 cycles, then release:
  - event_valid rises 6 cycles after the sampling edge; event_code = {0,2}.
  - After ack, a release event {1,2} follows the release.
- Press center with a 3-cycle glitch: buttons_level[4] stays 0; no event.
- Press left and down in the same cycle:
  - FIFO yields {0,0} then {0,3} on consecutive pushes.
  - buttons_level = 5'b01001.
- Generate 6 events with no ack:
  - FIFO holds 4, pending holds 2, overflow = 0.
  - Ack all six; codes arrive in order.
  - Then repeat a press on a button whose press is still pending: overflow = 1 until clear_overflow.
- Toggle switches to 16'hA5C3: switches_sync = 16'hA5C3 after two edges; no events.
